// File: rtl/reflex_timer.sv
// Reaction-time trial controller: random go delay from an 8-bit LFSR, a BCD
// millisecond counter and a record-time compare that requests a new best.
module reflex_timer #(
    parameter int TICK_DIV  = 100000,
    parameter int MIN_DELAY = 1000
) (
    input  logic       ck,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] rec0,
    input  logic [3:0] rec1,
    input  logic [3:0] rec2,
    input  logic [3:0] rec3,
    output logic [3:0] cnt0,
    output logic [3:0] cnt1,
    output logic [3:0] cnt2,
    output logic [3:0] cnt3,
    output logic       write_enable,
    output logic       led_go,
    output logic       early,
    output logic       busy
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_EARLY = 3'd4;

    localparam int              PS_W    = $clog2(TICK_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);
    localparam int               DLY_W   = $clog2(MIN_DELAY + 4 * 255 + 1);
    localparam logic [DLY_W-1:0] DLY_MIN = DLY_W'(MIN_DELAY);
    localparam logic [DLY_W-1:0] DLY_ONE = DLY_W'(1);

    logic [2:0]       state_r, state_s;
    logic [7:0]       lfsr_r;
    logic [PS_W-1:0]  presc_r, presc_s;
    logic [DLY_W-1:0] delay_r, delay_s;
    logic [15:0]      cnt_r, cnt_s;
    logic [15:0]      rec_s;
    logic             we_r, we_s;
    logic             led_go_r, early_r, busy_r;
    logic             timing_s, tick_s;

    // Fibonacci step for x^8+x^6+x^5+x^4+1; a nonzero seed never reaches zero.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        lfsr_step = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                    carry       = 1'b1;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        bcd_inc = r;
    endfunction

    assign rec_s    = {rec3, rec2, rec1, rec0};
    assign timing_s = (state_r == ST_WAIT) || (state_r == ST_RUN);
    assign tick_s   = timing_s && (presc_r == PS_LAST);

    // Next-state, prescaler, delay and counter decisions.
    always_comb begin
        state_s = state_r;
        delay_s = delay_r;
        cnt_s   = cnt_r;
        we_s    = 1'b0;
        presc_s = tick_s ? {PS_W{1'b0}} : (presc_r + PS_ONE);
        case (state_r)
            ST_IDLE, ST_DONE, ST_EARLY: begin
                if (start) begin
                    state_s = ST_WAIT;
                    cnt_s   = 16'h0000;
                    delay_s = DLY_MIN + DLY_W'({lfsr_r, 2'b00});
                end else begin
                    state_s = state_r;
                end
            end
            ST_WAIT: begin
                if (stop) begin
                    state_s = ST_EARLY;
                end else if (tick_s) begin
                    if (delay_r <= DLY_ONE) begin
                        state_s = ST_RUN;
                        delay_s = {DLY_W{1'b0}};
                    end else begin
                        delay_s = delay_r - DLY_ONE;
                    end
                end else begin
                    delay_s = delay_r;
                end
            end
            ST_RUN: begin
                // Stop beats a coincident tick so the displayed time is what was pressed.
                if (stop) begin
                    state_s = ST_DONE;
                    we_s    = (cnt_r < rec_s);
                end else if (tick_s) begin
                    if (cnt_r == 16'h9999) begin
                        state_s = ST_DONE;
                    end else begin
                        cnt_s = bcd_inc(cnt_r);
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        if ((state_s != ST_WAIT && state_s != ST_RUN) || (state_s != state_r)) begin
            presc_s = {PS_W{1'b0}};
        end else begin
            presc_s = presc_s;
        end
    end

    // State and registered outputs; reset dominates every other input.
    always_ff @(posedge ck) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            lfsr_r   <= 8'h01;
            presc_r  <= {PS_W{1'b0}};
            delay_r  <= {DLY_W{1'b0}};
            cnt_r    <= 16'h0000;
            we_r     <= 1'b0;
            led_go_r <= 1'b0;
            early_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            lfsr_r   <= lfsr_step(lfsr_r);
            presc_r  <= presc_s;
            delay_r  <= delay_s;
            cnt_r    <= cnt_s;
            we_r     <= we_s;
            led_go_r <= (state_s == ST_RUN);
            early_r  <= (state_s == ST_EARLY);
            busy_r   <= (state_s == ST_WAIT) || (state_s == ST_RUN);
        end
    end

    assign cnt0         = cnt_r[3:0];
    assign cnt1         = cnt_r[7:4];
    assign cnt2         = cnt_r[11:8];
    assign cnt3         = cnt_r[15:12];
    assign write_enable = we_r;
    assign led_go       = led_go_r;
    assign early        = early_r;
    assign busy         = busy_r;

endmodule
